// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse packet accumulator: FSM state codes,
// PS/2 control bytes, header bit positions and the per-axis delta decoder.
package mouse_pkg;

    // Packet assembly states, kept as plain vectors for legacy tool flows.
    localparam logic [1:0] S_HDR = 2'd0;
    localparam logic [1:0] S_X   = 2'd1;
    localparam logic [1:0] S_Y   = 2'd2;
    localparam logic [1:0] S_Z   = 2'd3;

    // Control bytes the device sends outside packets.
    localparam logic [7:0] PS2_ACK = 8'hFA;
    localparam logic [7:0] PS2_BAT = 8'hAA;

    // Header byte bit positions.
    localparam int HDR_BTN_L   = 0;
    localparam int HDR_BTN_R   = 1;
    localparam int HDR_BTN_M   = 2;
    localparam int HDR_ALWAYS1 = 3;
    localparam int HDR_X_SIGN  = 4;
    localparam int HDR_Y_SIGN  = 5;
    localparam int HDR_X_OVF   = 6;
    localparam int HDR_Y_OVF   = 7;

    // Turns one axis byte plus its header sign/overflow bits into a signed
    // delta. An overflowed axis reports the extreme of its direction.
    function automatic logic signed [9:0] axis_delta(input logic       sgn,
                                                     input logic       ovf,
                                                     input logic [7:0] b);
        if (ovf) begin
            return sgn ? -10'sd256 : 10'sd255;
        end
        return $signed({sgn, sgn, b});
    endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Saturating two's-complement adder: the result clamps to the most positive
// or most negative W-bit value instead of wrapping.
module sat_add_signed #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    logic signed [W:0] wide;

    // Add one bit wider, then clamp when the top two bits disagree.
    always_comb begin
        wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        if (wide[W] != wide[W-1]) begin
            sum_o = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_o = wide[W-1:0];
        end
    end

endmodule

// File: rtl/mouse_packet_accumulator.sv
// PS/2 mouse packet accumulator. Assembles 3/4-byte packets from the byte
// receiver, sums X/Y motion between move ticks with saturation, and presents
// a held magnitude+direction velocity per tick. Resyncs on mid-packet idle.
// Assumes ACC_W >= 10 and VEL_W <= ACC_W+1.
//
// Handshake: byte_rdy and move_tick are levels from other logic; only their
// rising edge (after a 2-FF sampler) means anything. byte_data must be stable
// while byte_rdy is high. pkt_valid and pkt_err are single-cycle pulses with
// no back-pressure; all other outputs are held registers.
module mouse_packet_accumulator
    import mouse_pkg::*;
#(
    parameter int PKT_BYTES   = 4,
    parameter int ACC_W       = 12,
    parameter int VEL_W       = 10,
    parameter int VEL_SHIFT   = 0,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_rdy,
    input  logic [7:0]       byte_data,
    input  logic             move_tick,
    output logic             pkt_valid,
    output logic             btn_left,
    output logic             btn_right,
    output logic             btn_middle,
    output logic [VEL_W-1:0] vel_x_mag,
    output logic             vel_x_neg,
    output logic [VEL_W-1:0] vel_y_mag,
    output logic             vel_y_down,
    output logic [3:0]       wheel,
    output logic             pkt_err,
    output logic [1:0]       dbg_state
);

    localparam int MAG_W   = ACC_W + 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 2);
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [MAG_W-1:0] VEL_CAP = MAG_W'((64'd1 << VEL_W) - 64'd1);

    // Edge samplers
    logic [1:0] byte_samp_q, tick_samp_q;
    logic       byte_rise, tick_rise;

    // Packet assembly
    logic [1:0]      state_q, state_d;
    logic [2:0]      hdr_btn_q, hdr_btn_d;
    logic [1:0]      hdr_sign_q, hdr_sign_d;   // [0]=X, [1]=Y
    logic [1:0]      hdr_ovf_q, hdr_ovf_d;     // [0]=X, [1]=Y
    logic [7:0]      x_q, x_d, y_q, y_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            pkt_done, hdr_err, to_hit;
    logic [3:0]      wheel_d;

    // Accumulation
    logic signed [9:0]       dx, dy;
    logic signed [ACC_W-1:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;
    logic signed [ACC_W-1:0] base_x, base_y, inc_x, inc_y;

    // Output registers
    logic             pkt_valid_q, pkt_err_q;
    logic [2:0]       btn_q;
    logic [3:0]       wheel_q;
    logic [VEL_W-1:0] vel_x_q, vel_y_q;
    logic             vel_x_neg_q, vel_y_down_q;

    // |a| >> VEL_SHIFT clamped to the output width; computed one bit wider so
    // the most negative accumulator value has a representable magnitude.
    function automatic logic [VEL_W-1:0] vel_mag(input logic signed [ACC_W-1:0] a);
        logic signed [MAG_W-1:0] wide;
        logic [MAG_W-1:0]        mag;
        logic [MAG_W-1:0]        sh;
        wide = {a[ACC_W-1], a};
        mag  = wide[MAG_W-1] ? -wide : wide;
        sh   = mag >> VEL_SHIFT;
        if (sh > VEL_CAP) begin
            return '1;
        end
        return sh[VEL_W-1:0];
    endfunction

    assign byte_rise = (byte_samp_q == 2'b01);
    assign tick_rise = (tick_samp_q == 2'b01);

    // Packet FSM: one step per received byte, idle timeout while mid-packet.
    always_comb begin
        state_d    = state_q;
        hdr_btn_d  = hdr_btn_q;
        hdr_sign_d = hdr_sign_q;
        hdr_ovf_d  = hdr_ovf_q;
        x_d        = x_q;
        y_d        = y_q;
        to_cnt_d   = to_cnt_q;
        pkt_done   = 1'b0;
        hdr_err    = 1'b0;
        to_hit     = 1'b0;
        if (byte_rise) begin
            to_cnt_d = '0;
            case (state_q)
                S_HDR: begin
                    if (byte_data == PS2_ACK || byte_data == PS2_BAT) begin
                        state_d = S_HDR;
                    end else if (!byte_data[HDR_ALWAYS1]) begin
                        hdr_err = 1'b1;
                    end else begin
                        hdr_btn_d  = {byte_data[HDR_BTN_M], byte_data[HDR_BTN_R],
                                      byte_data[HDR_BTN_L]};
                        hdr_sign_d = {byte_data[HDR_Y_SIGN], byte_data[HDR_X_SIGN]};
                        hdr_ovf_d  = {byte_data[HDR_Y_OVF], byte_data[HDR_X_OVF]};
                        state_d    = S_X;
                    end
                end
                S_X: begin
                    x_d     = byte_data;
                    state_d = S_Y;
                end
                S_Y: begin
                    y_d = byte_data;
                    if (PKT_BYTES == 4) begin
                        state_d = S_Z;
                    end else begin
                        state_d  = S_HDR;
                        pkt_done = 1'b1;
                    end
                end
                default: begin
                    state_d  = S_HDR;
                    pkt_done = 1'b1;
                end
            endcase
        end else if (state_q != S_HDR && TIMEOUT_CYC != 0) begin
            if (to_cnt_q == TO_W'(TO_LAST)) begin
                to_hit   = 1'b1;
                state_d  = S_HDR;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Packet deltas and adder operands: a tick clears the running sum, and a
    // packet finishing in the same cycle seeds the cleared sum.
    always_comb begin
        dx      = axis_delta(hdr_sign_q[0], hdr_ovf_q[0], x_q);
        dy      = axis_delta(hdr_sign_q[1], hdr_ovf_q[1], y_d);
        wheel_d = (PKT_BYTES == 4) ? byte_data[3:0] : 4'd0;
        base_x  = tick_rise ? '0 : acc_x_q;
        base_y  = tick_rise ? '0 : acc_y_q;
        inc_x   = pkt_done ? ACC_W'(dx) : '0;
        inc_y   = pkt_done ? ACC_W'(dy) : '0;
    end

    sat_add_signed #(.W(ACC_W)) u_add_x (
        .a_i  (base_x),
        .b_i  (inc_x),
        .sum_o(acc_x_d)
    );

    sat_add_signed #(.W(ACC_W)) u_add_y (
        .a_i  (base_y),
        .b_i  (inc_y),
        .sum_o(acc_y_d)
    );

    // State, accumulators and held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_samp_q  <= '0;
            tick_samp_q  <= '0;
            state_q      <= S_HDR;
            hdr_btn_q    <= '0;
            hdr_sign_q   <= '0;
            hdr_ovf_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            to_cnt_q     <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            pkt_valid_q  <= 1'b0;
            pkt_err_q    <= 1'b0;
            btn_q        <= '0;
            wheel_q      <= '0;
            vel_x_q      <= '0;
            vel_y_q      <= '0;
            vel_x_neg_q  <= 1'b0;
            vel_y_down_q <= 1'b0;
        end else begin
            byte_samp_q <= {byte_samp_q[0], byte_rdy};
            tick_samp_q <= {tick_samp_q[0], move_tick};
            state_q     <= state_d;
            hdr_btn_q   <= hdr_btn_d;
            hdr_sign_q  <= hdr_sign_d;
            hdr_ovf_q   <= hdr_ovf_d;
            x_q         <= x_d;
            y_q         <= y_d;
            to_cnt_q    <= to_cnt_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            pkt_valid_q <= pkt_done;
            pkt_err_q   <= hdr_err | to_hit;
            if (pkt_done) begin
                btn_q   <= hdr_btn_q;
                wheel_q <= wheel_d;
            end
            if (tick_rise) begin
                vel_x_q      <= vel_mag(acc_x_q);
                vel_y_q      <= vel_mag(acc_y_q);
                vel_x_neg_q  <= acc_x_q[ACC_W-1];
                vel_y_down_q <= acc_y_q[ACC_W-1];
            end
        end
    end

    assign pkt_valid  = pkt_valid_q;
    assign pkt_err    = pkt_err_q;
    assign btn_left   = btn_q[0];
    assign btn_right  = btn_q[1];
    assign btn_middle = btn_q[2];
    assign wheel      = wheel_q;
    assign vel_x_mag  = vel_x_q;
    assign vel_y_mag  = vel_y_q;
    assign vel_x_neg  = vel_x_neg_q;
    assign vel_y_down = vel_y_down_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mouse_packet_accumulator.sv
// Testbench for mouse_packet_accumulator: directed scenarios followed by
// randomized packets/ticks, compared against an arithmetic reference model.
module tb_mouse_packet_accumulator;

    localparam int PKT_BYTES   = 4;
    localparam int ACC_W       = 12;
    localparam int VEL_W       = 10;
    localparam int VEL_SHIFT   = 0;
    localparam int TIMEOUT_CYC = 200;
    localparam int ACC_MAX     = 2 ** (ACC_W - 1) - 1;
    localparam int ACC_MIN     = -(2 ** (ACC_W - 1));
    localparam int VEL_MAX     = 2 ** VEL_W - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             byte_rdy = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             move_tick = 1'b0;
    logic             pkt_valid, btn_left, btn_right, btn_middle;
    logic [VEL_W-1:0] vel_x_mag, vel_y_mag;
    logic             vel_x_neg, vel_y_down, pkt_err;
    logic [3:0]       wheel;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int pv_seen = 0;
    int err_seen = 0;

    // Reference model state
    int       m_acc_x, m_acc_y, m_vx, m_vy, m_pv, m_err;
    bit       m_xneg, m_ydown;
    bit [2:0] m_btn;
    bit [3:0] m_wheel;

    mouse_packet_accumulator #(
        .PKT_BYTES  (PKT_BYTES),
        .ACC_W      (ACC_W),
        .VEL_W      (VEL_W),
        .VEL_SHIFT  (VEL_SHIFT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .move_tick (move_tick),
        .pkt_valid (pkt_valid),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_middle(btn_middle),
        .vel_x_mag (vel_x_mag),
        .vel_x_neg (vel_x_neg),
        .vel_y_mag (vel_y_mag),
        .vel_y_down(vel_y_down),
        .wheel     (wheel),
        .pkt_err   (pkt_err),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Pulse counters; a pulse held longer than one cycle counts more than once.
    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pv_seen++;
        if (pkt_err === 1'b1) err_seen++;
    end

    // Global time limit
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int delta(input bit sgn, input bit ovf, input logic [7:0] b);
        if (ovf) return sgn ? -256 : 255;
        return sgn ? int'(b) - 256 : int'(b);
    endfunction

    function automatic int sat(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    function automatic int vmag(input int a);
        int m;
        m = (a < 0) ? -a : a;
        m = m >>> VEL_SHIFT;
        return (m > VEL_MAX) ? VEL_MAX : m;
    endfunction

    task automatic model_reset();
        m_acc_x = 0; m_acc_y = 0; m_vx = 0; m_vy = 0;
        m_xneg = 0; m_ydown = 0; m_btn = 0; m_wheel = 0;
    endtask

    task automatic model_packet(input logic [7:0] h, input logic [7:0] x,
                                input logic [7:0] y, input logic [7:0] z);
        m_acc_x = sat(m_acc_x + delta(h[4], h[6], x));
        m_acc_y = sat(m_acc_y + delta(h[5], h[7], y));
        m_btn   = h[2:0];
        m_wheel = z[3:0];
        m_pv++;
    endtask

    task automatic model_tick();
        m_vx = vmag(m_acc_x);
        m_vy = vmag(m_acc_y);
        m_xneg = (m_acc_x < 0);
        m_ydown = (m_acc_y < 0);
        m_acc_x = 0;
        m_acc_y = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data = b;
        byte_rdy = 1'b1;
        cyc(3);
        byte_rdy = 1'b0;
        cyc(3);
    endtask

    task automatic check_pkt(input string tag);
        chk({tag, "_pv"}, pv_seen, m_pv);
        chk({tag, "_btn"}, {btn_middle, btn_right, btn_left}, m_btn);
        chk({tag, "_wheel"}, wheel, m_wheel);
        chk({tag, "_err"}, err_seen, m_err);
    endtask

    task automatic send_packet(input string tag, input logic [7:0] h, input logic [7:0] x,
                               input logic [7:0] y, input logic [7:0] z);
        send_byte(h);
        send_byte(x);
        send_byte(y);
        send_byte(z);
        model_packet(h, x, y, z);
        check_pkt(tag);
    endtask

    task automatic check_vel(input string tag);
        chk({tag, "_vx"}, vel_x_mag, m_vx);
        chk({tag, "_xneg"}, vel_x_neg, m_xneg);
        chk({tag, "_vy"}, vel_y_mag, m_vy);
        chk({tag, "_ydown"}, vel_y_down, m_ydown);
    endtask

    task automatic send_tick(input string tag);
        move_tick = 1'b1;
        cyc(3);
        move_tick = 1'b0;
        cyc(3);
        model_tick();
        check_vel(tag);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        logic [7:0] h, x, y, z;
        m_pv = 0;
        m_err = 0;
        model_reset();

        // Reset state
        cyc(4);
        chk("rst_state", dbg_state, 0);
        chk("rst_pv", pkt_valid, 0);
        chk("rst_err", pkt_err, 0);
        check_vel("rst");
        chk("rst_wheel", wheel, 0);
        rst = 1'b0;
        cyc(2);

        // Single packet, +5 X
        send_packet("t1", 8'h08, 8'h05, 8'h00, 8'h00);
        send_tick("t1");
        chk("t1_vx_const", vel_x_mag, 5);

        // -5 then +3 sums to -2; an empty interval reports zero
        send_packet("t2a", 8'h18, 8'hFB, 8'h00, 8'h00);
        send_packet("t2b", 8'h08, 8'h03, 8'h00, 8'h00);
        send_tick("t2");
        chk("t2_vx_const", vel_x_mag, 2);
        chk("t2_xneg_const", vel_x_neg, 1);
        send_tick("t2_empty");
        chk("t2_empty_vx_const", vel_x_mag, 0);

        // X overflow packets saturate the accumulator, magnitude clamps
        for (int i = 0; i < 20; i++) send_packet("t3", 8'h48, 8'h10, 8'h00, 8'h00);
        send_tick("t3");
        chk("t3_vx_const", vel_x_mag, VEL_MAX);

        // Bad header, ignored control bytes, control values as packet data
        send_byte(8'h07);
        m_err++;
        chk("t4_bad_err", err_seen, m_err);
        chk("t4_bad_state", dbg_state, 0);
        send_byte(8'hFA);
        send_byte(8'hAA);
        chk("t4_ctrl_err", err_seen, m_err);
        chk("t4_ctrl_state", dbg_state, 0);
        send_packet("t4", 8'h28, 8'h00, 8'hFA, 8'h00);
        send_tick("t4");
        chk("t4_vy_const", vel_y_mag, 6);
        chk("t4_ydown_const", vel_y_down, 1);

        // Mid-packet stall triggers resync; the fragment is discarded
        send_byte(8'h08);
        send_byte(8'h05);
        cyc(TIMEOUT_CYC + 20);
        m_err++;
        chk("t5_to_err", err_seen, m_err);
        chk("t5_to_state", dbg_state, 0);
        send_packet("t5", 8'h09, 8'h07, 8'h00, 8'h0E);
        send_tick("t5");

        // Tick rise coinciding with the final byte
        send_packet("t6a", 8'h08, 8'h04, 8'h00, 8'h00);
        send_byte(8'h08);
        send_byte(8'h02);
        send_byte(8'h00);
        byte_data = 8'h05;
        byte_rdy = 1'b1;
        move_tick = 1'b1;
        cyc(3);
        byte_rdy = 1'b0;
        move_tick = 1'b0;
        cyc(3);
        model_tick();
        model_packet(8'h08, 8'h02, 8'h00, 8'h05);
        check_vel("t6_coinc");
        check_pkt("t6_coinc");
        send_tick("t6_next");

        // Reset mid-packet: outputs clear, no error pulse, clean restart
        send_packet("t6b", 8'h3F, 8'h11, 8'h22, 8'h03);
        send_tick("t6b");
        send_byte(8'h0B);
        send_byte(8'h05);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        model_reset();
        check_vel("t6_rst");
        check_pkt("t6_rst");
        chk("t6_rst_state", dbg_state, 0);
        send_packet("t6c", 8'h0A, 8'h03, 8'h00, 8'h00);
        send_tick("t6c");

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            h = 8'($urandom_range(0, 255)) | 8'h08;
            if ($urandom_range(0, 7) != 0) h[7:6] = 2'b00;
            if (h == 8'hFA || h == 8'hAA) h[7:6] = 2'b00;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            z = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) send_byte(8'hFA);
            send_packet("rnd", h, x, y, z);
            if ($urandom_range(0, 2) == 0) send_tick("rnd");
        end
        send_tick("rnd_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
